// File: rtl/btn_event_pkg.sv
// Shared types and constants for the button event block: FSM state encodings,
// default 100 MHz debounce/hold timing, and a counter-width helper.
// Combinational helpers only; no timing or flow control involved.
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2
  } btn_state_e;

  // 10 ms debounce and 1 s long-press hold at 100 MHz
  localparam int DEF_DB_CYCLES   = 1_000_000;
  localparam int DEF_HOLD_CYCLES = 100_000_000;

  // Width of a counter that must reach n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_event_if.sv
// Bundle of the raw pin input and the cleaned-up event outputs of one button.
// No storage; the slave side is the btn_event block, the master side drives the pin.
// No backpressure: strobes are one-cycle events that consumers must sample.
interface btn_event_if;
  logic       btn_raw;
  logic       btn_level;
  logic       press;
  logic       btn_release;
  logic [7:0] press_cnt;
  logic       long_press;

  modport master (
    output btn_raw,
    input  btn_level,
    input  press,
    input  btn_release,
    input  press_cnt,
    input  long_press
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press,
    output btn_release,
    output press_cnt,
    output long_press
  );
endinterface

// File: rtl/btn_event_sync.sv
// Two-flop synchronizer for one asynchronous input bit, with a reset value.
// Latency: two clock edges from input change to output change.
// No backpressure: output follows the input every cycle.
module btn_event_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Metastability stage followed by a clean stage; both reset to the idle level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/btn_event.sv
// Debounces one bouncy async button into a level, press/release/long-press strobes and a press count.
// Latency: 2 + DB_CYCLES edges from a clean raw change to btn_level/press (+1 for async sampling).
// No backpressure: strobes last exactly one cycle. Long press is built only with `BTN_LONG_PRESS_EN.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  btn_event_if.slave  io_bus
);

  localparam int                DB_W    = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            w_lvl;
  logic            w_s;
  logic            w_differ;
  logic            w_accept;
  logic            w_rise;
  logic            w_fall;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_level;
  logic            r_press;
  logic            r_release;
  logic [7:0]      r_press_cnt;
  btn_state_e      r_state;
  btn_state_e      w_state_nxt;

  // Normalise polarity so that 1 always means pressed before synchronising
  assign w_lvl = (ACTIVE_HIGH != 0) ? io_bus.btn_raw : ~io_bus.btn_raw;

  btn_event_sync #(
    .RST_VAL (1'b0)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (w_lvl),
    .o_q   (w_s)
  );

  // A level change is accepted once the synchronised input has disagreed for DB_CYCLES samples in a row
  assign w_differ = (w_s != r_btn_level);
  assign w_accept = w_differ && (r_db_cnt == DB_LAST);
  assign w_rise   = w_accept &&  w_s;
  assign w_fall   = w_accept && !w_s;

  // Debounce counter, debounced level, edge strobes and press counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_db_cnt    <= '0;
      r_btn_level <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      if (!w_differ || w_accept) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      if (w_accept) begin
        r_btn_level <= w_s;
      end
      r_press   <= w_rise;
      r_release <= w_fall;
      if (w_rise) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int                HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_long_press;
  logic              w_long_nxt;

  // Hold counter and registered long-press strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_cnt   <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_hold_cnt   <= w_hold_nxt;
      r_long_press <= w_long_nxt;
    end
  end

  // Next state: transitions ride the same edge that updates btn_level; a release beats hold expiry
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_long_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_DOWN;
          w_hold_nxt  = '0;
        end
      end
      ST_DOWN: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_LONG;
          w_long_nxt  = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign io_bus.long_press = r_long_press;
`else
  // Hold time has no effect when long press is not built
  if (HOLD_CYCLES < 1) begin : g_hold_ignored
  end

  // Next state: only pressed/not-pressed is tracked
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign io_bus.long_press = 1'b0;
`endif

  assign io_bus.btn_level   = r_btn_level;
  assign io_bus.press       = r_press;
  assign io_bus.btn_release = r_release;
  assign io_bus.press_cnt   = r_press_cnt;

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: table of clean-press vectors, hand-written corner sequences and
// random raw waveforms, all compared against a sample-history reference model.
module tb_btn_event;

  localparam int DB   = 4;
  localparam int HOLD = 16;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_event_if bus();

  btn_event #(
    .DB_CYCLES   (DB),
    .HOLD_CYCLES (HOLD),
    .ACTIVE_HIGH (1)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Observed strobe statistics
  int edge_n     = 0;
  int n_press    = 0;
  int n_rel      = 0;
  int n_long     = 0;
  int press_edge = 0;
  int long_edge  = 0;

  // Reference model: raw delayed two samples, then a level flips once the last DB
  // samples since the previous flip all disagree with it.
  bit       m_dly[$];
  bit       m_samp[$];
  bit       m_level;
  bit       m_press;
  bit       m_rel;
  bit       m_long;
  bit [7:0] m_cnt;
  bit       m_armed;
  int       m_held;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_edge(input bit raw, input bit r);
    bit s;
    bit flip;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (r) begin
      m_dly.delete();
      m_dly.push_back(1'b0);
      m_dly.push_back(1'b0);
      m_samp.delete();
      m_level = 1'b0;
      m_cnt   = 8'd0;
      m_armed = 1'b0;
      m_held  = 0;
    end else begin
      s = m_dly.pop_front();
      m_dly.push_back(raw);
      m_samp.push_back(s);
      if (m_samp.size() > DB) void'(m_samp.pop_front());
      flip = (m_samp.size() == DB);
      foreach (m_samp[i]) if (m_samp[i] == m_level) flip = 1'b0;
      if (flip) begin
        m_level = s;
        m_samp.delete();
        if (s) begin
          m_press = 1'b1;
          m_cnt   = m_cnt + 8'd1;
          m_armed = LONG_EN;
          m_held  = 0;
        end else begin
          m_rel   = 1'b1;
          m_armed = 1'b0;
        end
      end else if (m_level && m_armed) begin
        m_held++;
        if (m_held == HOLD) begin
          m_long  = 1'b1;
          m_armed = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input bit raw, input bit r);
    logic [11:0] act;
    logic [11:0] exp;
    bus.btn_raw = raw;
    rst         = r;
    @(posedge clk);
    edge_n++;
    model_edge(raw, r);
    @(negedge clk);
    act = {bus.btn_level, bus.press, bus.btn_release, bus.press_cnt, bus.long_press};
    exp = {m_level, m_press, m_rel, m_cnt, m_long};
    check("model", int'(act), int'(exp));
    if (bus.press === 1'b1) begin
      n_press++;
      press_edge = edge_n;
    end
    if (bus.btn_release === 1'b1) n_rel++;
    if (bus.long_press === 1'b1) begin
      n_long++;
      long_edge = edge_n;
    end
  endtask

  typedef struct {
    bit       raw;
    bit       rst;
    bit       lvl;
    bit       press;
    bit [7:0] cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int p0;
    int r0;
    int l0;
    int c0;
    bit raw;
    int run;

    bus.btn_raw = 1'b0;

    // Clean press: level and press appear at the sixth edge after raw rises
    tbl[0] = '{raw: 1'b0, rst: 1'b1, lvl: 1'b0, press: 1'b0, cnt: 8'd0};
    tbl[1] = '{raw: 1'b0, rst: 1'b0, lvl: 1'b0, press: 1'b0, cnt: 8'd0};
    for (int k = 1; k <= 8; k++) begin
      tbl[k+1] = '{raw: 1'b1, rst: 1'b0, lvl: (k >= 6), press: (k == 6),
                   cnt: (k >= 6) ? 8'd1 : 8'd0};
    end
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].raw, tbl[i].rst);
      check("vec_level", int'(bus.btn_level), int'(tbl[i].lvl));
      check("vec_press", int'(bus.press), int'(tbl[i].press));
      check("vec_release", int'(bus.btn_release), 0);
      check("vec_cnt", int'(bus.press_cnt), int'(tbl[i].cnt));
    end

    // Long press: keep holding to 30 raw-high cycles, then let go
    l0 = n_long;
    r0 = n_rel;
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
    check("long_count", n_long - l0, LONG_EN ? 1 : 0);
    if (LONG_EN) check("long_offset", long_edge - press_edge, HOLD);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("long_release", n_rel - r0, 1);
    check("long_level", int'(bus.btn_level), 0);

    // Bounce: two-cycle toggles then a steady press gives exactly one press
    p0 = n_press;
    c0 = int'(bus.press_cnt);
    for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check("bounce_press", n_press - p0, 1);
    check("bounce_cnt", int'(bus.press_cnt), (c0 + 1) % 256);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Glitch: three high cycles is one short of the debounce window
    p0 = n_press;
    c0 = int'(bus.press_cnt);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("glitch_press", n_press - p0, 0);
    check("glitch_cnt", int'(bus.press_cnt), c0);
    check("glitch_level", int'(bus.btn_level), 0);

    // Random raw waveforms with occasional resets
    raw = 1'b0;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        raw = ~raw;
        run = $urandom_range(1, 24);
      end
      run--;
      step(raw, ($urandom_range(0, 199) == 0));
    end

    // Wrap: 256 clean presses from reset bring the counter back to zero
    step(1'b0, 1'b1);
    p0 = n_press;
    r0 = n_rel;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
      if (n == 254) check("wrap_cnt_255", int'(bus.press_cnt), 255);
    end
    check("wrap_presses", n_press - p0, 256);
    check("wrap_releases", n_rel - r0, 256);
    check("wrap_cnt_0", int'(bus.press_cnt), 0);

    // Reset mid-hold: outputs clear, held button is re-debounced from scratch
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check("hold_level_pre", int'(bus.btn_level), 1);
    step(1'b1, 1'b1);
    check("rst_outputs", int'({bus.btn_level, bus.press, bus.btn_release, bus.press_cnt, bus.long_press}), 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0);
      check("rst_press", int'(bus.press), (k == 6) ? 1 : 0);
      check("rst_level", int'(bus.btn_level), (k >= 6) ? 1 : 0);
    end
    check("rst_cnt", int'(bus.press_cnt), 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
